tick_period_meter: RTL and testbench

//  Measures the spacing, in clk cycles, between consecutive one-cycle pulses on tick_in.

---
 rtl/tick_period_meter.sv | 144 ++++++++++++++
 tb/tb_tick_period_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures the spacing in clk cycles between consecutive tick_in events (one event per high cycle).
// Optional macro TICK_PERIOD_AVG_EN averages four consecutive periods per start.
module tick_period_meter #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         tick_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] period,
   output logic         ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_MEASURE
   } state_t;

   state_t       r_state, w_state_next;
   logic [N-1:0] r_cnt, w_cnt_next;
   logic [N-1:0] r_period, w_period_next;
   logic         r_busy, w_busy_next;
   logic         r_done, w_done_next;
   logic         r_ovf, w_ovf_next;
   logic         w_cnt_max;

`ifdef TICK_PERIOD_AVG_EN
   logic [N+1:0] r_acc, w_acc_next;
   logic [N+1:0] w_sum;
   logic [1:0]   r_sub, w_sub_next;

   // Sum including the sub-period closing this cycle
   assign w_sum = r_acc + {2'b00, r_cnt};
`endif

   assign w_cnt_max = (r_cnt == {N{1'b1}});

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_period <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
`ifdef TICK_PERIOD_AVG_EN
         r_acc    <= '0;
         r_sub    <= '0;
`endif
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_period <= w_period_next;
         r_busy   <= w_busy_next;
         r_done   <= w_done_next;
         r_ovf    <= w_ovf_next;
`ifdef TICK_PERIOD_AVG_EN
         r_acc    <= w_acc_next;
         r_sub    <= w_sub_next;
`endif
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_period_next = r_period;
      w_busy_next   = r_busy;
      w_done_next   = 1'b0;
      w_ovf_next    = r_ovf;
`ifdef TICK_PERIOD_AVG_EN
      w_acc_next    = r_acc;
      w_sub_next    = r_sub;
`endif
      case (r_state)
         S_IDLE: begin
            // An event coinciding with start is deliberately not counted
            if (start) begin
               w_state_next = S_ARM;
               w_busy_next  = 1'b1;
               w_cnt_next   = '0;
`ifdef TICK_PERIOD_AVG_EN
               w_acc_next   = '0;
               w_sub_next   = '0;
`endif
            end
         end
         S_ARM: begin
            if (tick_in) begin
               w_cnt_next   = N'(1);
               w_state_next = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (tick_in) begin
`ifdef TICK_PERIOD_AVG_EN
               if (r_sub != 2'd3) begin
                  w_acc_next = w_sum;
                  w_sub_next = r_sub + 2'd1;
                  w_cnt_next = N'(1);
               end else begin
                  w_period_next = N'(w_sum >> 2);
                  w_ovf_next    = 1'b0;
                  w_done_next   = 1'b1;
                  w_busy_next   = 1'b0;
                  w_cnt_next    = '0;
                  w_state_next  = S_IDLE;
               end
`else
               w_period_next = r_cnt;
               w_ovf_next    = 1'b0;
               w_done_next   = 1'b1;
               w_busy_next   = 1'b0;
               w_cnt_next    = '0;
               w_state_next  = S_IDLE;
`endif
            end else if (w_cnt_max) begin
               // Counter saturated without a closing event: report overflow instead of wrapping
               w_period_next = {N{1'b1}};
               w_ovf_next    = 1'b1;
               w_done_next   = 1'b1;
               w_busy_next   = 1'b0;
               w_cnt_next    = '0;
               w_state_next  = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + N'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign period = r_period;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a 16-bit instance and a 4-bit instance for overflow cases.
module tb_tick_period_meter;

`ifdef TICK_PERIOD_AVG_EN
   localparam int NSUB = 4;
`else
   localparam int NSUB = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_a = 1'b0, tick_a = 1'b0;
   logic        start_b = 1'b0, tick_b = 1'b0;
   logic        busy_a, done_a, ovf_a;
   logic [15:0] period_a;
   logic        busy_b, done_b, ovf_b;
   logic [3:0]  period_b;

   int n_total = 0;
   int n_pass  = 0;
   int early   = 0;

   always #5 clk = ~clk;

   tick_period_meter #(.N(16)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .tick_in(tick_a),
      .busy(busy_a), .done(done_a), .period(period_a), .ovf(ovf_a)
   );

   tick_period_meter #(.N(4)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .tick_in(tick_b),
      .busy(busy_b), .done(done_b), .period(period_b), .ovf(ovf_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive one cycle on the selected instance; outputs are settled 1 time unit after the edge
   task automatic cyc(input bit sel, input logic st, input logic tk);
      if (sel) begin
         start_b = st; tick_b = tk; start_a = 1'b0; tick_a = 1'b0;
      end else begin
         start_a = st; tick_a = tk; start_b = 1'b0; tick_b = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic cur_done(input bit sel);
      return sel ? done_b : done_a;
   endfunction

   // m-1 quiet cycles then a closing event; a done before the event is counted as early
   task automatic gap(input bit sel, input int m);
      for (int c = 1; c < m; c++) begin
         cyc(sel, 1'b0, 1'b0);
         if (cur_done(sel)) early++;
      end
      cyc(sel, 1'b0, 1'b1);
   endtask

   // start, first event, then NSUB sub-periods; intermediate closes must not raise done
   task automatic meas(input bit sel, input int g0, input int g1, input int g2, input int g3);
      int g[4];
      g = '{g0, g1, g2, g3};
      early = 0;
      cyc(sel, 1'b1, 1'b0);
      cyc(sel, 1'b0, 1'b1);
      for (int k = 0; k < NSUB; k++) begin
         gap(sel, g[k]);
         if (k < NSUB - 1 && cur_done(sel)) early++;
      end
      check("no_early_done", early, 0);
   endtask

   task automatic check_a(input string tag, input logic [15:0] p, input logic o);
      check({tag, "_done"}, done_a, 1);
      check({tag, "_period"}, period_a, p);
      check({tag, "_ovf"}, ovf_a, o);
      check({tag, "_busy"}, busy_a, 0);
      cyc(1'b0, 1'b0, 1'b0);
      check({tag, "_done_1cyc"}, done_a, 0);
   endtask

   initial begin
      // 1: reset with start and tick_in high
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_a = 1'b1; tick_a = 1'b1; start_b = 1'b1; tick_b = 1'b1;
         @(posedge clk);
         #1;
         check("rst_busy", busy_a, 0);
         check("rst_done", done_a, 0);
         check("rst_period", period_a, 0);
         check("rst_ovf", ovf_a, 0);
         check("rst_ovf_n4", ovf_b, 0);
      end
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      $display("step reset: busy=%0d done=%0d period=%0d", busy_a, done_a, period_a);

      // 2: mod-10 tick stream
      cyc(1'b0, 1'b1, 1'b0);
      check("start_busy", busy_a, 1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      early = 0;
      for (int k = 0; k < NSUB; k++) begin
         gap(1'b0, 10);
         if (k < NSUB - 1 && done_a) early++;
      end
      check("m10_no_early", early, 0);
      $display("step m10: period=%0d ovf=%0d", period_a, ovf_a);
      check_a("m10", 16'd10, 1'b0);

      // 3: tick_in held high, then re-armed in the done cycle
      cyc(1'b0, 1'b1, 1'b1);
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 0; k <= NSUB; k++) begin
            cyc(1'b0, 1'b0, 1'b1);
            check("held_done_timing", done_a, (k == NSUB) ? 1 : 0);
         end
         check("held_period", period_a, 1);
         check("held_ovf", ovf_a, 0);
         $display("step held rep%0d: period=%0d", rep, period_a);
         if (rep == 0) begin
            cyc(1'b0, 1'b1, 1'b1);
            check("rearm_busy", busy_a, 1);
         end
      end
      cyc(1'b0, 1'b0, 1'b0);
      check("held_done_1cyc", done_a, 0);

      // 4: N=4 overflow 15 cycles after the event, then exact max and M=7
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      early = 0;
      for (int i = 1; i < 15; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         if (done_b) early++;
      end
      check("ovf_no_early", early, 0);
      cyc(1'b1, 1'b0, 1'b0);
      check("ovf_done", done_b, 1);
      check("ovf_flag", ovf_b, 1);
      check("ovf_period", period_b, 4'hF);
      check("ovf_busy", busy_b, 0);
      $display("step n4 ovf: period=%0h ovf=%0d", period_b, ovf_b);
      meas(1'b1, 15, 15, 15, 15);
      check("max_done", done_b, 1);
      check("max_period", period_b, 4'hF);
      check("max_ovf", ovf_b, 0);
      meas(1'b1, 7, 7, 7, 7);
      check("m7_done", done_b, 1);
      check("m7_period", period_b, 7);
      check("m7_ovf", ovf_b, 0);
      $display("step n4 m7: period=%0d ovf=%0d", period_b, ovf_b);

      // 5: starts in ARM and mid-MEASURE are ignored
      early = 0;
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cyc(1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0);
         if (done_a) early++;
      end
      cyc(1'b0, 1'b0, 1'b1);
      for (int k = 1; k < NSUB; k++) begin
         if (done_a) early++;
         gap(1'b0, 10);
      end
      check("ignstart_no_early", early, 0);
      $display("step ignored start: period=%0d", period_a);
      check_a("ignstart", 16'd10, 1'b0);

      // 5b: reset mid-MEASURE aborts without done
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      check("abort_busy", busy_a, 0);
      check("abort_done", done_a, 0);
      check("abort_period", period_a, 0);
      reset = 1'b1;
      early = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b0, (i % 3 == 0) ? 1'b1 : 1'b0);
         if (done_a || busy_a) early++;
      end
      check("abort_stays_idle", early, 0);
      $display("step abort: busy=%0d done=%0d", busy_a, done_a);

      // 6: averaging (single-period 11 when averaging is not built)
      meas(1'b0, 10, 10, 11, 11);
`ifdef TICK_PERIOD_AVG_EN
      check_a("avg42", 16'd10, 1'b0);
`else
      check_a("single10", 16'd10, 1'b0);
      meas(1'b0, 11, 11, 11, 11);
      check_a("single11", 16'd11, 1'b0);
`endif
      meas(1'b0, 12, 12, 12, 12);
      $display("step 12s: period=%0d", period_a);
      check_a("m12", 16'd12, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
